// File: rtl/ysyx_mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// requester IDs and default bus widths.
package ysyx_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_mem_arbiter_if.sv
// Bundles the two requester ports and the single memory port of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's.
interface ysyx_mem_arbiter_if #(
  parameter int unsigned ADDR_W = ysyx_mem_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = ysyx_mem_pkg::DATA_W_DEF
);

  logic [1:0]            m_req_valid;
  logic [1:0]            m_req_ready;
  logic [2*ADDR_W-1:0]   m_req_addr;
  logic [1:0]            m_req_wen;
  logic [2*DATA_W-1:0]   m_req_wdata;
  logic [2*DATA_W/8-1:0] m_req_wmask;
  logic [1:0]            m_resp_valid;
  logic [1:0]            m_resp_ready;
  logic [DATA_W-1:0]     m_resp_rdata;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_resp_valid;
  logic                  mem_resp_ready;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  busy;

  modport slave (
    input  m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wmask, m_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output m_req_ready, m_resp_valid, m_resp_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready, busy
  );

  modport master (
    output m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wmask, m_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  m_req_ready, m_resp_valid, m_resp_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready, busy
  );

endinterface

// File: rtl/ysyx_mem_arbiter_pick.sv
// Combinational winner selection between IFU (0) and LSU (1).
// ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise the LSU wins ties.
module ysyx_arb_pick
  import ysyx_mem_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_winner,
  output logic       o_any_valid
);

  assign o_any_valid = |i_valid;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    if (&i_valid) begin
      o_winner = ~i_last_grant;
    end else begin
      o_winner = i_valid[1] ? REQ_LSU : REQ_IFU;
    end
  end
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;

  always_comb begin
    o_winner = i_valid[1] ? REQ_LSU : REQ_IFU;
  end
`endif

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Two-requester data-memory arbiter, one transaction in flight (IDLE -> ISSUE -> WAIT).
// Tie-break policy lives in ysyx_arb_pick and is selected by ARB_ROUND_ROBIN_EN.
module ysyx_mem_arbiter
  import ysyx_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic               clk,
  input logic               rst,
  ysyx_mem_arbiter_if.slave bus
);

  localparam int unsigned MASK_W = DATA_W / 8;

  state_e              r_state;
  state_e              w_state_next;
  logic                r_grant;
  logic                r_last_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;

  logic                w_winner;
  logic                w_any_valid;
  logic                w_accept;
  logic                w_resp_done;

  ysyx_arb_pick u_pick (
    .i_valid      (bus.m_req_valid),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any_valid  (w_any_valid)
  );

  always_comb begin
    w_state_next       = r_state;
    w_accept           = 1'b0;
    w_resp_done        = 1'b0;
    bus.m_req_ready    = '0;
    bus.m_resp_valid   = '0;
    bus.m_resp_rdata   = '0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_resp_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          bus.m_req_ready[w_winner] = 1'b1;
          w_accept                  = 1'b1;
          w_state_next              = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        // Response is steered only to the granted requester.
        bus.m_resp_valid[r_grant] = bus.mem_resp_valid;
        bus.mem_resp_ready        = bus.m_resp_ready[r_grant];
        bus.m_resp_rdata          = bus.mem_rdata;
        if (bus.mem_resp_valid && bus.m_resp_ready[r_grant]) begin
          w_resp_done  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= REQ_IFU;
      r_last_grant <= REQ_LSU;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_grant <= w_winner;
        r_addr  <= w_winner ? bus.m_req_addr[ADDR_W +: ADDR_W] : bus.m_req_addr[0 +: ADDR_W];
        r_wen   <= bus.m_req_wen[w_winner];
        r_wdata <= w_winner ? bus.m_req_wdata[DATA_W +: DATA_W] : bus.m_req_wdata[0 +: DATA_W];
        r_wmask <= w_winner ? bus.m_req_wmask[MASK_W +: MASK_W] : bus.m_req_wmask[0 +: MASK_W];
      end
      if (w_resp_done) begin
        r_last_grant <= r_grant;
      end
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wen   = r_wen;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wmask = r_wmask;
  assign bus.busy      = (r_state != IDLE);

endmodule
